// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the ROB writeback-port arbiter.
// Supplies default data/type/tag widths when the build does not define them.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

package wb_port_arbiter_pkg;

    localparam int PKG_WORD_SIZE     = `WORD_SIZE;
    localparam int PKG_INSTR_TYPE_SZ = `INSTR_TYPE_SZ;
    localparam int PKG_ROB_ID_W      = `ROB_ENTRY_WIDTH;

    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_MUL = 1;
    localparam int WB_SRC_MEM = 2;

    typedef struct packed {
        logic [PKG_INSTR_TYPE_SZ-1:0] instruction_type;
        logic [PKG_WORD_SIZE-1:0]     pc;
        logic [PKG_WORD_SIZE-1:0]     data;
        logic                         exception;
        logic [PKG_WORD_SIZE-1:0]     virtual_addr_exception;
        logic [PKG_ROB_ID_W-1:0]      rob_id;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_rr_grant.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo N_REQ.
// Purely combinational; returns a one-hot grant and the matching index.
module rr_grant #(
    parameter  int N_REQ = 3,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single ROB writeback port among the execution pipelines through a one-entry slot.
// WB_ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise the highest index wins.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter  int WORD_SIZE     = PKG_WORD_SIZE,
    parameter  int INSTR_TYPE_SZ = PKG_INSTR_TYPE_SZ,
    parameter  int N_REQ         = 3,
    localparam int IDX_W         = $clog2(N_REQ),
    localparam int ROB_W         = PKG_ROB_ID_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*INSTR_TYPE_SZ-1:0] req_instruction_type,
    input  logic [N_REQ*WORD_SIZE-1:0]     req_pc,
    input  logic [N_REQ*WORD_SIZE-1:0]     req_data,
    input  logic [N_REQ-1:0]               req_exception,
    input  logic [N_REQ*WORD_SIZE-1:0]     req_virtual_addr_exception,
    input  logic [N_REQ*ROB_W-1:0]         req_rob_id,
    input  logic                           rob_wb_ready,
    output logic                           wb_valid,
    output logic [INSTR_TYPE_SZ-1:0]       wb_instruction_type,
    output logic [WORD_SIZE-1:0]           wb_pc,
    output logic [WORD_SIZE-1:0]           wb_data,
    output logic                           wb_exception,
    output logic [WORD_SIZE-1:0]           wb_virtual_addr_exception,
    output logic [ROB_W-1:0]               wb_rob_id,
    output logic [IDX_W-1:0]               wb_src
);

    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_win;
    logic             w_slot_free;
    logic             w_accept;
    wb_entry_t        w_sel;
    wb_entry_t        r_slot;
    logic             r_wb_valid;
    logic [IDX_W-1:0] r_wb_src;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rr_ptr;

    rr_grant #(.N_REQ(N_REQ)) u_grant (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + IDX_W'(1);
        end
    end
`else
    logic [N_REQ-1:0] w_req_rev;
    logic [N_REQ-1:0] w_grant_rev;
    logic [IDX_W-1:0] w_idx_rev;

    // Bit-reversing the request vector turns a fixed pointer of zero into highest-index-first.
    always_comb begin
        w_req_rev = '0;
        w_grant   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_req_rev[k] = req_valid[N_REQ-1-k];
            w_grant[k]   = w_grant_rev[N_REQ-1-k];
        end
    end

    assign w_win = IDX_W'(N_REQ - 1) - w_idx_rev;

    rr_grant #(.N_REQ(N_REQ)) u_grant (
        .req   (w_req_rev),
        .ptr   ('0),
        .grant (w_grant_rev),
        .idx   (w_idx_rev)
    );
`endif

    assign w_slot_free = !r_wb_valid || rob_wb_ready;
    assign w_accept    = (|w_grant) && w_slot_free && !flush;
    assign req_ready   = w_grant & {N_REQ{w_slot_free && !flush && !reset}};

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel.instruction_type       = req_instruction_type[k*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
                w_sel.pc                     = req_pc[k*WORD_SIZE +: WORD_SIZE];
                w_sel.data                   = req_data[k*WORD_SIZE +: WORD_SIZE];
                w_sel.exception              = req_exception[k];
                w_sel.virtual_addr_exception = req_virtual_addr_exception[k*WORD_SIZE +: WORD_SIZE];
                w_sel.rob_id                 = req_rob_id[k*ROB_W +: ROB_W];
            end
        end
    end

    // Flush wins over both a consume and a new accept; payload is left as-is when the slot empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_slot     <= '0;
            r_wb_src   <= IDX_W'(WB_SRC_ALU);
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else if (w_accept) begin
            r_wb_valid <= 1'b1;
            r_slot     <= w_sel;
            r_wb_src   <= w_win;
        end else if (rob_wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign wb_valid                  = r_wb_valid;
    assign wb_instruction_type       = r_slot.instruction_type;
    assign wb_pc                     = r_slot.pc;
    assign wb_data                   = r_slot.data;
    assign wb_exception              = r_slot.exception;
    assign wb_virtual_addr_exception = r_slot.virtual_addr_exception;
    assign wb_rob_id                 = r_slot.rob_id;
    assign wb_src                    = r_wb_src;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes expected writebacks, a monitor checks consumes.
// Expected grant vectors follow WB_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int W  = PKG_WORD_SIZE;
    localparam int TW = PKG_INSTR_TYPE_SZ;
    localparam int RW = PKG_ROB_ID_W;
`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_instruction_type;
    logic [N*W-1:0]  req_pc;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_exception;
    logic [N*W-1:0]  req_virtual_addr_exception;
    logic [N*RW-1:0] req_rob_id;
    logic            rob_wb_ready;
    logic            wb_valid;
    logic [TW-1:0]   wb_instruction_type;
    logic [W-1:0]    wb_pc;
    logic [W-1:0]    wb_data;
    logic            wb_exception;
    logic [W-1:0]    wb_virtual_addr_exception;
    logic [RW-1:0]   wb_rob_id;
    logic [1:0]      wb_src;

    logic          t_v[N];
    logic [TW-1:0] t_itype[N];
    logic [W-1:0]  t_pc[N];
    logic [W-1:0]  t_data[N];
    logic          t_exc[N];
    logic [W-1:0]  t_vaddr[N];
    logic [RW-1:0] t_rob[N];

    typedef struct {
        wb_entry_t  e;
        logic [1:0] src;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk                        (clk),
        .reset                      (reset),
        .flush                      (flush),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .req_instruction_type       (req_instruction_type),
        .req_pc                     (req_pc),
        .req_data                   (req_data),
        .req_exception              (req_exception),
        .req_virtual_addr_exception (req_virtual_addr_exception),
        .req_rob_id                 (req_rob_id),
        .rob_wb_ready               (rob_wb_ready),
        .wb_valid                   (wb_valid),
        .wb_instruction_type        (wb_instruction_type),
        .wb_pc                      (wb_pc),
        .wb_data                    (wb_data),
        .wb_exception               (wb_exception),
        .wb_virtual_addr_exception  (wb_virtual_addr_exception),
        .wb_rob_id                  (wb_rob_id),
        .wb_src                     (wb_src)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]                          = t_v[i];
            req_instruction_type[i*TW +: TW]      = t_itype[i];
            req_pc[i*W +: W]                      = t_pc[i];
            req_data[i*W +: W]                    = t_data[i];
            req_exception[i]                      = t_exc[i];
            req_virtual_addr_exception[i*W +: W]  = t_vaddr[i];
            req_rob_id[i*RW +: RW]                = t_rob[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t cur(input int i);
        exp_t x;
        x.e.instruction_type       = t_itype[i];
        x.e.pc                     = t_pc[i];
        x.e.data                   = t_data[i];
        x.e.exception              = t_exc[i];
        x.e.virtual_addr_exception = t_vaddr[i];
        x.e.rob_id                 = t_rob[i];
        x.src                      = 2'(i);
        return x;
    endfunction

    task automatic set_valid(input logic [2:0] v);
        for (int i = 0; i < N; i++) t_v[i] = v[i];
    endtask

    // One clock of stimulus: check the expected grant, queue the winner, then present its next entry.
    task automatic cycle(input logic [2:0] exp_rdy, input bit push, input string nm);
        int idx;
        idx = exp_rdy[2] ? 2 : (exp_rdy[1] ? 1 : 0);
        @(negedge clk);
        #1;
        chk({"req_ready ", nm}, 64'(req_ready), 64'(exp_rdy));
        if (exp_rdy != 3'b000 && push) q.push_back(cur(idx));
        @(posedge clk);
        #1;
        if (exp_rdy != 3'b000) begin
            t_rob[idx]  = t_rob[idx] + 1'b1;
            t_pc[idx]   = t_pc[idx] + 4;
            t_data[idx] = t_data[idx] + 32'h101;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && !flush && wb_valid && rob_wb_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: wb_rob_id=%0d wb_src=%0d, expected no writeback", wb_rob_id, wb_src);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("wb_src", 64'(wb_src), 64'(x.src));
                chk("wb_rob_id", 64'(wb_rob_id), 64'(x.e.rob_id));
                chk("wb_pc", 64'(wb_pc), 64'(x.e.pc));
                chk("wb_data", 64'(wb_data), 64'(x.e.data));
                chk("wb_exception", 64'(wb_exception), 64'(x.e.exception));
                chk("wb_vaddr", 64'(wb_virtual_addr_exception), 64'(x.e.virtual_addr_exception));
                chk("wb_itype", 64'(wb_instruction_type), 64'(x.e.instruction_type));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        rob_wb_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            t_v[i]     = 1'b1;
            t_itype[i] = TW'(i + 1);
            t_exc[i]   = 1'b0;
            t_vaddr[i] = '0;
        end
        t_pc[0] = 32'h100; t_data[0] = 32'hA000_0000; t_rob[0] = 6'd1;
        t_pc[1] = 32'h200; t_data[1] = 32'hB000_0000; t_rob[1] = 6'd17;
        t_pc[2] = 32'h300; t_data[2] = 32'hC000_0000; t_rob[2] = 6'd33;

        // reset held with every requester valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset wb_valid", 64'(wb_valid), 64'd0);
        chk("reset wb_src", 64'(wb_src), 64'd0);
        chk("reset wb_rob_id", 64'(wb_rob_id), 64'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        rob_wb_ready = 1'b1;

        // all three valid continuously
        cycle(RR ? 3'b001 : 3'b100, 1'b1, "rr0");
        cycle(RR ? 3'b010 : 3'b100, 1'b1, "rr1");
        cycle(RR ? 3'b100 : 3'b100, 1'b1, "rr2");
        cycle(RR ? 3'b001 : 3'b100, 1'b1, "rr3");
        set_valid(3'b000);
        cycle(3'b000, 1'b0, "idle0");

        // back-pressure on a MUL entry with rob_id 5
        t_rob[1] = 6'd5;
        set_valid(3'b010);
        cycle(3'b010, 1'b1, "bp_accept");
        rob_wb_ready = 1'b0;
        set_valid(3'b001);
        for (int k = 0; k < 3; k++) begin
            cycle(3'b000, 1'b0, "bp_hold");
            chk("bp wb_valid", 64'(wb_valid), 64'd1);
            chk("bp wb_rob_id", 64'(wb_rob_id), 64'd5);
            chk("bp wb_src", 64'(wb_src), 64'(WB_SRC_MUL));
        end
        rob_wb_ready = 1'b1;
        cycle(3'b001, 1'b1, "bp_release");
        set_valid(3'b000);
        cycle(3'b000, 1'b0, "idle1");

        // flush kills an occupied slot even with requests pending
        set_valid(3'b100);
        cycle(3'b100, 1'b0, "fl_accept");
        rob_wb_ready = 1'b0;
        flush        = 1'b1;
        set_valid(3'b011);
        cycle(3'b000, 1'b0, "fl_kill");
        chk("flush wb_valid", 64'(wb_valid), 64'd0);
        flush        = 1'b0;
        rob_wb_ready = 1'b1;
        cycle(RR ? 3'b001 : 3'b010, 1'b1, "fl_after0");
        cycle(RR ? 3'b010 : 3'b010, 1'b1, "fl_after1");
        set_valid(3'b000);
        cycle(3'b000, 1'b0, "idle2");

        // MEM entry carrying an exception
        t_exc[2]   = 1'b1;
        t_vaddr[2] = 32'h40;
        t_pc[2]    = 32'd42;
        set_valid(3'b100);
        cycle(3'b100, 1'b1, "exc");
        t_exc[2]   = 1'b0;
        set_valid(3'b000);
        cycle(3'b000, 1'b0, "idle3");

        // lone ALU requester at full throughput
        set_valid(3'b001);
        for (int k = 0; k < 4; k++) cycle(3'b001, 1'b1, "single");
        set_valid(3'b000);
        cycle(3'b000, 1'b0, "idle4");

        // reset while the slot is occupied
        set_valid(3'b010);
        cycle(3'b010, 1'b0, "rst_fill");
        reset = 1'b1;
        #1;
        chk("midreset wb_valid", 64'(wb_valid), 64'd0);
        chk("midreset req_ready", 64'(req_ready), 64'd0);
        chk("midreset wb_rob_id", 64'(wb_rob_id), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(3'b010, 1'b1, "rst_after");
        set_valid(3'b000);
        cycle(3'b000, 1'b0, "idle5");

        @(negedge clk);
        #1;
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
